// File: rtl/crc_engine_if.sv
// Beat-in / bit-out handshake bundle for crc_engine.
interface crc_engine_if #(
  parameter int unsigned NBITS = 5,
  parameter int unsigned DW    = 8
);
  localparam int unsigned NW = $clog2(DW + 1);

  logic             start;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [NW-1:0]    in_nbits;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [NBITS-1:0] crc_out;
  logic             done;
  logic             match;

  modport master (
    output start, mode, in_valid, in_data, in_nbits, in_last, out_ready,
    input  in_ready, out_valid, out_bit, crc_out, done, match
  );

  modport slave (
    input  start, mode, in_valid, in_data, in_nbits, in_last, out_ready,
    output in_ready, out_valid, out_bit, crc_out, done, match
  );
endinterface

// File: rtl/crc_engine.sv
// Multi-bit-per-beat CRC engine. Absorbs up to DW bits per beat (bit 0 first),
// then either serialises ~crc MSB first (GENERATE) or compares against the residue (CHECK).
module crc_engine #(
  parameter int unsigned      NBITS    = 5,
  parameter logic [NBITS-1:0] POLY     = 5'h05,
  parameter logic [NBITS-1:0] INIT     = '1,
  parameter logic [NBITS-1:0] RESIDUAL = 5'h0C,
  parameter int unsigned      DW       = 8
) (
  input logic         clk,
  input logic         rst,
  crc_engine_if.slave bus
);
  localparam int unsigned NW = $clog2(DW + 1);
  localparam int unsigned CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e           r_state, w_state_n;
  logic [NBITS-1:0] r_crc, w_crc_n;
  logic [NBITS-1:0] r_crc_out, w_crc_out_n;
  logic [NBITS-1:0] r_shift, w_shift_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_mode, w_mode_n;
  logic             r_match, w_match_n;
  logic             r_done, w_done_n;

  logic [NW-1:0]    w_nsteps;
  logic [NBITS-1:0] w_beat_crc;
  logic             w_fb;

  // Oversized bit counts saturate at a full beat.
  assign w_nsteps = (bus.in_nbits > NW'(DW)) ? NW'(DW) : bus.in_nbits;

  // Unrolled LFSR: apply w_nsteps single-bit steps to the register, bit 0 first.
  always_comb begin
    w_beat_crc = r_crc;
    w_fb       = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (NW'(i) < w_nsteps) begin
        w_fb       = bus.in_data[i] ^ w_beat_crc[NBITS-1];
        w_beat_crc = (w_beat_crc << 1) ^ (w_fb ? POLY : '0);
      end
    end
  end

  // Next-state logic; start overrides everything, including a beat offered alongside it.
  always_comb begin
    w_state_n   = r_state;
    w_crc_n     = r_crc;
    w_crc_out_n = r_crc_out;
    w_shift_n   = r_shift;
    w_cnt_n     = r_cnt;
    w_mode_n    = r_mode;
    w_match_n   = r_match;
    w_done_n    = 1'b0;
    if (bus.start) begin
      w_state_n = StAccum;
      w_crc_n   = INIT;
      w_mode_n  = bus.mode;
      w_match_n = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
        end
        StAccum: begin
          if (bus.in_valid) begin
            w_crc_n = w_beat_crc;
            if (bus.in_last) begin
              w_crc_out_n = ~w_beat_crc;
              if (r_mode) begin
                w_shift_n = ~w_beat_crc;
                w_cnt_n   = CW'(NBITS);
                w_state_n = StEmit;
              end else begin
                w_match_n = (w_beat_crc == RESIDUAL);
                w_done_n  = 1'b1;
                w_state_n = StIdle;
              end
            end
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            w_shift_n = r_shift << 1;
            w_cnt_n   = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              w_done_n  = 1'b1;
              w_state_n = StIdle;
            end
          end
        end
        default: w_state_n = StIdle;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_crc     <= INIT;
      r_crc_out <= ~INIT;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_match   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_crc     <= w_crc_n;
      r_crc_out <= w_crc_out_n;
      r_shift   <= w_shift_n;
      r_cnt     <= w_cnt_n;
      r_mode    <= w_mode_n;
      r_match   <= w_match_n;
      r_done    <= w_done_n;
    end
  end

  assign bus.in_ready  = (r_state == StAccum) && !bus.start;
  assign bus.out_valid = (r_state == StEmit);
  // Gated so a packet aborted mid-emit leaves no stale bit visible.
  assign bus.out_bit   = (r_state == StEmit) && r_shift[NBITS-1];
  assign bus.crc_out   = r_crc_out;
  assign bus.done      = r_done;
  assign bus.match     = r_match;
endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: CRC5 instance checked every cycle against a polynomial-division
// model, CRC16 instance exercised with directed expectations.
module tb_crc_engine;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_engine_if #(.NBITS(5),  .DW(DW)) a_if ();
  crc_engine_if #(.NBITS(16), .DW(DW)) b_if ();

  crc_engine #(.NBITS(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUAL(5'h0C), .DW(DW)) u_crc5 (
    .clk(clk),
    .rst(rst),
    .bus(a_if.slave)
  );

  crc_engine #(.NBITS(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUAL(16'h800D), .DW(DW))
    u_crc16 (
    .clk(clk),
    .rst(rst),
    .bus(b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register after message = (INIT*x^L + M(x)*x^n) mod (x^n + poly), first bit highest degree.
  function automatic int unsigned crc_mod(input bit msg[$], input int n,
                                          input int unsigned poly, input int unsigned init);
    int          l;
    bit          d[];
    int unsigned r;
    l = msg.size();
    d = new[n + l];
    foreach (d[k]) d[k] = 1'b0;
    for (int j = 0; j < n; j++) if (init[j]) d[j + l] = 1'b1;
    for (int k = 0; k < l; k++) if (msg[k]) d[l - 1 - k + n] ^= 1'b1;
    for (int deg = n + l - 1; deg >= n; deg--) begin
      if (d[deg]) begin
        for (int j = 0; j < n; j++) if (poly[j]) d[deg - n + j] ^= 1'b1;
        d[deg] = 1'b0;
      end
    end
    r = 0;
    for (int j = 0; j < n; j++) if (d[j]) r |= (32'd1 << j);
    return r;
  endfunction

  // Model state for the CRC5 instance.
  bit         m_active;
  bit         m_mode;
  bit         m_bits[$];
  bit         m_emit[$];
  bit         m_done;
  bit         m_match;
  logic [4:0] m_crc_out;
  // Observed DUT activity.
  bit         g_emit[$];
  int         g_done_cnt = 0;

  // Compare CRC5 outputs each cycle on the falling edge, then advance the model past the
  // coming rising edge using the inputs that are stable until then.
  always @(negedge clk) begin
    int          nb;
    int unsigned crc;
    bit          done_nx;
    bit          exp_bit;
    if (rst) begin
      m_active  = 1'b0;
      m_mode    = 1'b0;
      m_bits.delete();
      m_emit.delete();
      m_done    = 1'b0;
      m_match   = 1'b0;
      m_crc_out = 5'h00;
    end
    exp_bit = (m_emit.size() > 0) ? m_emit[0] : 1'b0;
    check("in_ready",  a_if.in_ready,  m_active && !a_if.start);
    check("out_valid", a_if.out_valid, m_emit.size() > 0);
    check("out_bit",   a_if.out_bit,   exp_bit);
    check("done",      a_if.done,      m_done);
    check("match",     a_if.match,     m_match);
    check("crc_out",   a_if.crc_out,   m_crc_out);
    if (a_if.done) g_done_cnt++;
    if (!rst) begin
      if (!a_if.start && a_if.out_valid && a_if.out_ready) g_emit.push_back(a_if.out_bit);
      done_nx = 1'b0;
      if (a_if.start) begin
        m_active = 1'b1;
        m_mode   = a_if.mode;
        m_bits.delete();
        m_emit.delete();
        m_match  = 1'b0;
      end else if (m_active && a_if.in_valid) begin
        nb = (int'(a_if.in_nbits) > DW) ? DW : int'(a_if.in_nbits);
        for (int i = 0; i < nb; i++) m_bits.push_back(a_if.in_data[i]);
        if (a_if.in_last) begin
          crc       = crc_mod(m_bits, 5, 32'h05, 32'h1F);
          m_crc_out = 5'(~crc);
          m_active  = 1'b0;
          if (m_mode) begin
            for (int j = 4; j >= 0; j--) m_emit.push_back(~crc[j]);
          end else begin
            m_match = (crc == 32'h0C);
            done_nx = 1'b1;
          end
        end
      end else if (m_emit.size() > 0 && a_if.out_ready) begin
        void'(m_emit.pop_front());
        if (m_emit.size() == 0) done_nx = 1'b1;
      end
      m_done = done_nx;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start(input bit m);
    a_if.start = 1'b1;
    a_if.mode  = m;
    cyc();
    a_if.start = 1'b0;
  endtask

  task automatic a_beat(input logic [7:0] d, input logic [3:0] n, input bit last);
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.in_nbits = n;
    a_if.in_last  = last;
    cyc();
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c0;
    c0 = g_done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (g_done_cnt != c0) break;
      cyc();
    end
    check({name, "_done_once"}, g_done_cnt - c0, 1);
  endtask

  function automatic logic [4:0] emitted();
    logic [4:0] v;
    v = '0;
    foreach (g_emit[i]) v = {v[3:0], g_emit[i]};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    a_if.start = 0; a_if.mode = 0; a_if.in_valid = 0; a_if.in_data = '0;
    a_if.in_nbits = '0; a_if.in_last = 0; a_if.out_ready = 0;
    b_if.start = 0; b_if.mode = 0; b_if.in_valid = 0; b_if.in_data = '0;
    b_if.in_nbits = '0; b_if.in_last = 0; b_if.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_crc_out5",   a_if.crc_out,   5'h00);
    check("rst_crc_out16",  b_if.crc_out,   16'h0000);
    check("rst_in_ready16", b_if.in_ready,  0);
    check("rst_out_valid16", b_if.out_valid, 0);
    rst = 1'b0;
    cyc();

    // 1: CRC16, empty final beat, register stays at INIT.
    b_if.out_ready = 1'b1;
    b_if.start = 1'b1; b_if.mode = 1'b1;
    cyc();
    b_if.start = 1'b0;
    b_if.in_valid = 1'b1; b_if.in_nbits = '0; b_if.in_last = 1'b1; b_if.in_data = 8'hA5;
    cyc();
    b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
    check("t1_crc_out", b_if.crc_out, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      check("t1_out_valid", b_if.out_valid, 1);
      check("t1_out_bit",   b_if.out_bit,   0);
      check("t1_no_done",   b_if.done,      0);
      cyc();
    end
    check("t1_done",       b_if.done,      1);
    check("t1_valid_drop", b_if.out_valid, 0);
    cyc();
    check("t1_done_pulse", b_if.done,      0);

    // 2: GENERATE over 11 zero bits, then CHECK with the emitted CRC appended.
    a_if.out_ready = 1'b1;
    g_emit.delete();
    a_start(1'b1);
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'hF8, 4'd3, 1'b1);
    wait_done("t2_gen", 20);
    check("t2_gen_crc_out", a_if.crc_out, 5'h08);
    check("t2_gen_bits",    emitted(),    5'b01000);
    check("t2_gen_nbits",   g_emit.size(), 5);
    a_start(1'b0);
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'h10, 4'd8, 1'b1);
    wait_done("t2_chk", 10);
    check("t2_match",   a_if.match,   1);
    check("t2_residue", a_if.crc_out, 5'h13);

    // 3: one data bit flipped.
    c0 = g_done_cnt;
    a_start(1'b0);
    a_beat(8'h01, 4'd8, 1'b0);
    a_beat(8'h10, 4'd8, 1'b1);
    wait_done("t3", 10);
    repeat (3) cyc();
    check("t3_match",      a_if.match,      0);
    check("t3_done_count", g_done_cnt - c0, 1);

    // 4: out_ready toggling during EMIT.
    a_if.out_ready = 1'b0;
    g_emit.delete();
    a_start(1'b1);
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'h00, 4'd3, 1'b1);
    c0 = g_done_cnt;
    for (int i = 0; i < 40; i++) begin
      if (g_done_cnt != c0) break;
      a_if.out_ready = i[0];
      cyc();
    end
    check("t4_done_once", g_done_cnt - c0, 1);
    check("t4_bits",      emitted(),       5'b01000);
    check("t4_nbits",     g_emit.size(),   5);

    // 5: restart mid-ACCUM (with a beat offered) and mid-EMIT.
    c0 = g_done_cnt;
    a_if.out_ready = 1'b0;
    a_start(1'b1);
    a_beat(8'h00, 4'd8, 1'b0);
    a_if.in_valid = 1'b1; a_if.in_data = 8'hFF; a_if.in_nbits = 4'd8;
    a_start(1'b1);
    a_if.in_valid = 1'b0;
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'h00, 4'd3, 1'b1);
    cyc();
    a_if.out_ready = 1'b1;
    cyc();
    a_if.out_ready = 1'b0;
    a_start(1'b1);
    check("t5_no_done", g_done_cnt - c0, 0);
    g_emit.delete();
    a_if.out_ready = 1'b1;
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'h00, 4'd3, 1'b1);
    wait_done("t5", 20);
    check("t5_crc_out", a_if.crc_out, 5'h08);
    check("t5_bits",    emitted(),    5'b01000);

    // 7: in_nbits above DW clamps to a full beat.
    a_start(1'b0);
    a_beat(8'h00, 4'd15, 1'b0);
    a_beat(8'h10, 4'd8,  1'b1);
    wait_done("t7", 10);
    check("t7_match", a_if.match, 1);

    // 6: asynchronous reset mid-EMIT.
    a_if.out_ready = 1'b0;
    a_start(1'b1);
    a_beat(8'h00, 4'd8, 1'b0);
    a_beat(8'h00, 4'd3, 1'b1);
    cyc();
    check("t6_in_emit", a_if.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", a_if.out_valid, 0);
    check("t6_out_bit",   a_if.out_bit,   0);
    check("t6_done",      a_if.done,      0);
    check("t6_match",     a_if.match,     0);
    check("t6_in_ready",  a_if.in_ready,  0);
    check("t6_crc_out",   a_if.crc_out,   5'h00);
    check("t6_crc_out16", b_if.crc_out,   16'h0000);
    cyc();
    rst = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_nbits = 4'd8;
    repeat (3) cyc();
    check("t6_no_ready", a_if.in_ready, 0);
    a_if.in_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
